// File: rtl/sobol_seq_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : sobol_seq_gen_if
// Description : Direction-table load, run control and valid/ready point stream
//               for one Sobol dimension.
// Revision    : 1.0 - initial release
// ============================================================================
interface sobol_seq_gen_if #(
    parameter int WIDTH = 32,
    parameter int NBITS = 32,
    parameter int CNT_W = 32
);
    localparam int A_W = $clog2(NBITS);

    logic             dir_we;
    logic [A_W-1:0]   dir_addr;
    logic [NBITS-1:0] dir_data;
    logic             start;
    logic [CNT_W-1:0] num_samples;
    logic             out_ready;
    logic             valid_out;
    logic [WIDTH-1:0] u;
    logic             busy;
    logic             done;

    modport master (
        output dir_we, dir_addr, dir_data, start, num_samples, out_ready,
        input  valid_out, u, busy, done
    );

    modport slave (
        input  dir_we, dir_addr, dir_data, start, num_samples, out_ready,
        output valid_out, u, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/sobol_seq_gen.sv
`default_nettype none
// ============================================================================
// Module      : sobol_seq_gen
// Description : 1-D Sobol generator, Gray-code form, Q16.16 output in (0,1),
//               run-loadable direction table, valid/ready output stream.
// Revision    : 1.0 - initial release
// ============================================================================
module sobol_seq_gen #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16,
    parameter int NBITS = 32,
    parameter int CNT_W = 32
) (
    input  wire             clk,
    input  wire             rst,
    sobol_seq_gen_if.slave  bus
);
    localparam int A_W   = $clog2(NBITS);
    localparam int C_LIM = (NBITS - 1 < CNT_W) ? NBITS - 1 : CNT_W;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [NBITS-1:0] r_dir [NBITS];
    logic [NBITS-1:0] r_x;
    logic [CNT_W-1:0] r_n;
    logic [CNT_W-1:0] r_gen;
    logic [CNT_W-1:0] r_emit;
    logic [CNT_W-1:0] r_target;
    logic             r_valid;
    logic [WIDTH-1:0] r_u;

    logic             w_step;
    logic             w_xfer;
    logic             w_last;
    logic             w_launch;
    logic [A_W-1:0]   w_c;
    logic             w_seen0;
    logic [NBITS-1:0] w_x_next;
    logic [FRAC-1:0]  w_field;
    logic [WIDTH-1:0] w_u_next;

    assign w_xfer   = r_valid && bus.out_ready;
    assign w_last   = w_xfer && ((r_emit + c_cnt_one) == r_target);
    assign w_step   = (r_state == S_RUN) && (!r_valid || bus.out_ready) && (r_gen < r_target);
    assign w_launch = (r_state == S_IDLE) && bus.start && (bus.num_samples != '0);

    // Index of the lowest zero bit of n selects the direction number to fold in.
    always_comb begin
        w_c     = '0;
        w_seen0 = 1'b0;
        for (int i = 0; i < C_LIM; i++) begin
            if (!w_seen0) begin
                if (r_n[i]) w_c = A_W'(i + 1);
                else        w_seen0 = 1'b1;
            end
        end
    end

    assign w_x_next = r_x ^ r_dir[w_c];
    assign w_field  = w_x_next[NBITS-1 -: FRAC];
    assign w_u_next = (w_field == '0) ? {{(WIDTH-1){1'b0}}, 1'b1}
                                      : {{(WIDTH-FRAC){1'b0}}, w_field};

    // Direction table survives reset so a restart replays the same sequence.
    always_ff @(posedge clk) begin
        if (bus.dir_we && (r_state == S_IDLE)) begin
            r_dir[bus.dir_addr] <= bus.dir_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (bus.start) w_state_next = (bus.num_samples != '0) ? S_RUN : S_DONE;
            S_RUN:  if (w_last)    w_state_next = S_DONE;
            S_DONE: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (r_state == S_RUN);
        bus.done = (r_state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x      <= '0;
            r_n      <= '0;
            r_gen    <= '0;
            r_emit   <= '0;
            r_target <= '0;
            r_valid  <= 1'b0;
            r_u      <= '0;
        end else if (w_launch) begin
            r_target <= bus.num_samples;
            r_x      <= '0;
            r_n      <= '0;
            r_gen    <= '0;
            r_emit   <= '0;
        end else begin
            if (w_xfer) r_emit <= r_emit + c_cnt_one;
            if (w_step) begin
                r_x     <= w_x_next;
                r_n     <= r_n + c_cnt_one;
                r_gen   <= r_gen + c_cnt_one;
                r_u     <= w_u_next;
                r_valid <= 1'b1;
            end else if (w_xfer) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.valid_out = r_valid;
    assign bus.u         = r_u;
endmodule
`default_nettype wire

// File: tb/tb_sobol_seq_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_sobol_seq_gen
// Description : Self-checking bench; Gray-code XOR reference model and a
//               per-cycle stream comparator.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sobol_seq_gen;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sobol_seq_gen_if #(.WIDTH(32), .NBITS(32), .CNT_W(32)) bus ();

    sobol_seq_gen #(.WIDTH(32), .FRAC(16), .NBITS(32), .CNT_W(32)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int          checks   = 0;
    int          failures = 0;
    int          xfer_cnt = 0;
    logic [31:0] tbl [32];
    logic [31:0] exp_q [$];
    logic        p_hold = 1'b0;
    logic [31:0] p_u    = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Point i is the XOR of v[k] over the set bits of gray(i).
    function automatic logic [31:0] model_u(input int unsigned i);
        logic [31:0] g;
        logic [31:0] x;
        g = i ^ (i >> 1);
        x = '0;
        for (int k = 0; k < 32; k++) if (g[k]) x = x ^ tbl[k];
        if (x[31:16] == 16'h0) return 32'd1;
        return {16'h0, x[31:16]};
    endfunction

    task automatic write_dir(input int k, input logic [31:0] val, input bit track);
        @(posedge clk); #1;
        bus.dir_we   = 1'b1;
        bus.dir_addr = k[4:0];
        bus.dir_data = val;
        if (track) tbl[k] = val;
        @(posedge clk); #1;
        bus.dir_we = 1'b0;
    endtask

    task automatic start_run(input int unsigned n);
        @(posedge clk); #1;
        bus.start       = 1'b1;
        bus.num_samples = n;
        xfer_cnt        = 0;
        for (int unsigned i = 1; i <= n; i++) exp_q.push_back(model_u(i));
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit rnd);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk); #1;
            if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=no_done required=done_within_%0d", budget);
        end else begin
            chk("busy_at_done", bus.busy, 0);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (p_hold) begin
                chk("hold_valid", bus.valid_out, 1);
                chk("hold_u", bus.u, p_u);
            end
            if (bus.valid_out && bus.out_ready) begin
                xfer_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL stream_extra actual=0x%0h required=no_point", bus.u);
                end else begin
                    chk("stream_u", bus.u, exp_q.pop_front());
                end
            end
            if (bus.valid_out) chk("valid_implies_busy", bus.busy, 1);
            p_hold = bus.valid_out && !bus.out_ready;
            p_u    = bus.u;
        end else begin
            p_hold = 1'b0;
        end
    end

    initial begin
        logic [31:0] lit [4];
        lit[0] = 32'h8000; lit[1] = 32'hC000; lit[2] = 32'h4000; lit[3] = 32'h6000;

        rst             = 1'b1;
        bus.dir_we      = 1'b0;
        bus.dir_addr    = '0;
        bus.dir_data    = '0;
        bus.start       = 1'b0;
        bus.num_samples = '0;
        bus.out_ready   = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", bus.valid_out, 0);
        chk("rst_u", bus.u, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int k = 0; k < 32; k++) write_dir(k, 32'h8000_0000 >> k, 1'b1);
        for (int i = 0; i < 4; i++) chk("model_pin", model_u(i + 1), lit[i]);

        // Basic timing and values
        start_run(4);
        @(negedge clk);
        chk("t1_busy", bus.busy, 1);
        chk("t1_novalid", bus.valid_out, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t1_valid", bus.valid_out, 1);
            chk("t1_u", bus.u, lit[i]);
        end
        @(negedge clk);
        chk("t1_done", bus.done, 1);
        chk("t1_busy_low", bus.busy, 0);
        chk("t1_valid_low", bus.valid_out, 0);
        @(negedge clk);
        chk("t1_done_pulse", bus.done, 0);

        // Backpressure
        bus.out_ready = 1'b0;
        start_run(3);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t2_held_valid", bus.valid_out, 1);
            chk("t2_held_u", bus.u, 32'h8000);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            else       @(negedge clk);
            chk("t2_valid", bus.valid_out, 1);
            chk("t2_u", bus.u, lit[i]);
        end
        wait_done(10, 1'b0);
        chk("t2_count", xfer_cnt, 3);

        // Clamp
        write_dir(0, 32'h0000_0001, 1'b1);
        start_run(1);
        @(negedge clk);
        @(negedge clk);
        chk("t3_valid", bus.valid_out, 1);
        chk("t3_clamp", bus.u, 32'h1);
        wait_done(10, 1'b0);
        write_dir(0, 32'h8000_0000, 1'b1);

        // Zero count
        start_run(0);
        @(negedge clk);
        chk("t4_done", bus.done, 1);
        chk("t4_busy", bus.busy, 0);
        chk("t4_valid", bus.valid_out, 0);
        @(negedge clk);
        chk("t4_done_pulse", bus.done, 0);
        chk("t4_valid2", bus.valid_out, 0);

        // Reset mid-run
        start_run(8);
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("t5_valid", bus.valid_out, 0);
        chk("t5_busy", bus.busy, 0);
        start_run(2);
        wait_done(10, 1'b0);
        chk("t5_count", xfer_cnt, 2);

        // Table writes and start ignored while running
        start_run(5);
        @(negedge clk);
        @(posedge clk); #1;
        bus.dir_we      = 1'b1;
        bus.dir_addr    = 5'd0;
        bus.dir_data    = 32'h0;
        bus.start       = 1'b1;
        bus.num_samples = 2;
        @(posedge clk); #1;
        bus.dir_we = 1'b0;
        bus.start  = 1'b0;
        wait_done(20, 1'b0);
        chk("t6_len", xfer_cnt, 5);
        start_run(1);
        @(negedge clk);
        @(negedge clk);
        chk("t6_u", bus.u, 32'h8000);
        wait_done(10, 1'b0);

        // Randomized tables, lengths and backpressure
        for (int r = 0; r < 10; r++) begin
            int unsigned n;
            for (int k = 0; k < 32; k++) write_dir(k, $urandom, 1'b1);
            n = $urandom_range(1, 24);
            start_run(n);
            wait_done(400, 1'b1);
            chk("rnd_count", xfer_cnt, n);
            chk("rnd_drained", exp_q.size(), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
